// File: rtl/cursor_motion_ctrl.sv
// Cursor sprite sequencer: per-frame motion commit and click pulse animation.
// Optional CURSOR_WRAP_EN: commit wraps around the screen instead of clamping.
module cursor_motion_ctrl #(
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 639,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 479,
    parameter int X_CENTER   = 320,
    parameter int Y_CENTER   = 240,
    parameter int SIZE_REST  = 4,
    parameter int SIZE_PEAK  = 10,
    parameter int PULSE_STEP = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       move_valid,
    output logic       move_ready,
    input  logic [8:0] move_dx,
    input  logic [8:0] move_dy,
    input  logic       click,
    output logic [9:0] CursorX,
    output logic [9:0] CursorY,
    output logic [9:0] CursorSize,
    output logic       pulse_active
);

    typedef enum logic [1:0] {
        REST,
        GROW,
        SHRINK
    } state_t;

    localparam logic [9:0] SR = 10'(SIZE_REST);
    localparam logic [9:0] SP = 10'(SIZE_PEAK);
    localparam logic [9:0] PS = 10'(PULSE_STEP);

    state_t            state;
    logic              fs1, fs2, fs3;
    logic [1:0]        live;
    logic              armed;
    logic              tick;
    logic              tick_nxt;
    logic              click_d;
    logic              click_pending;
    logic signed [9:0] acc_x, acc_y;

    function automatic logic [9:0] sat_add(input logic [9:0] a,
                                           input logic [8:0] d);
        logic signed [10:0] s;
        s = {a[9], a} + {{2{d[8]}}, d};
        if (s > 11'sd511)
            return 10'd511;
        else if (s < -11'sd511)
            return 10'h201;
        else
            return s[9:0];
    endfunction

    function automatic logic [9:0] commit(input logic [9:0] pos,
                                          input logic [9:0] acc,
                                          input int lo,
                                          input int hi);
        logic signed [11:0] s;
        s = {2'b00, pos} + {{2{acc[9]}}, acc};
`ifdef CURSOR_WRAP_EN
        if (s > hi)
            s = s - 12'(hi - lo + 1);
        else if (s < lo)
            s = s + 12'(hi - lo + 1);
`else
        if (s > hi)
            s = 12'(hi);
        else if (s < lo)
            s = 12'(lo);
`endif
        return s[9:0];
    endfunction

    // Ignore rises until the synchronizer has sampled frame_clk low once.
    assign tick_nxt = fs2 & ~fs3 & armed;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fs1           <= 1'b0;
            fs2           <= 1'b0;
            fs3           <= 1'b0;
            live          <= 2'b00;
            armed         <= 1'b0;
            tick          <= 1'b0;
            move_ready    <= 1'b0;
            click_d       <= 1'b0;
            click_pending <= 1'b0;
            acc_x         <= '0;
            acc_y         <= '0;
            state         <= REST;
            pulse_active  <= 1'b0;
            CursorX       <= 10'(X_CENTER);
            CursorY       <= 10'(Y_CENTER);
            CursorSize    <= SR;
        end else begin
            fs1        <= frame_clk;
            fs2        <= fs1;
            fs3        <= fs2;
            live       <= {live[0], 1'b1};
            armed      <= armed | (live[1] & ~fs2);
            tick       <= tick_nxt;
            move_ready <= ~tick_nxt;
            click_d    <= click;

            if (tick) begin
                CursorX <= commit(CursorX, acc_x, X_MIN, X_MAX);
                CursorY <= commit(CursorY, acc_y, Y_MIN, Y_MAX);
                acc_x   <= '0;
                acc_y   <= '0;
            end else if (move_valid && move_ready) begin
                acc_x <= sat_add(acc_x, move_dx);
                acc_y <= sat_add(acc_y, move_dy);
            end

            if (tick && state == REST && click_pending)
                click_pending <= 1'b0;
            else if (click && !click_d && state == REST)
                click_pending <= 1'b1;

            if (tick) begin
                unique case (state)
                    REST: begin
                        if (click_pending) begin
                            CursorSize   <= CursorSize + PS;
                            pulse_active <= 1'b1;
                            state <= (CursorSize + PS == SP) ? SHRINK : GROW;
                        end
                    end
                    GROW: begin
                        CursorSize <= CursorSize + PS;
                        if (CursorSize + PS == SP)
                            state <= SHRINK;
                    end
                    SHRINK: begin
                        CursorSize <= CursorSize - PS;
                        if (CursorSize - PS == SR) begin
                            state        <= REST;
                            pulse_active <= 1'b0;
                        end
                    end
                    default: begin
                        state        <= REST;
                        pulse_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cursor_motion_ctrl.sv
// Directed bench for cursor_motion_ctrl with a queue of expected commits.
module tb_cursor_motion_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       move_valid = 1'b0;
    logic [8:0] move_dx = '0;
    logic [8:0] move_dy = '0;
    logic       click = 1'b0;
    logic       move_ready;
    logic [9:0] CursorX, CursorY, CursorSize;
    logic       pulse_active;

    cursor_motion_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .move_valid  (move_valid),
        .move_ready  (move_ready),
        .move_dx     (move_dx),
        .move_dy     (move_dy),
        .click       (click),
        .CursorX     (CursorX),
        .CursorY     (CursorY),
        .CursorSize  (CursorSize),
        .pulse_active(pulse_active)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] s;
        logic       pa;
    } exp_t;

`ifdef CURSOR_WRAP_EN
    localparam logic [9:0] X_SAT_HI = 10'd194;
    localparam logic [9:0] X_SAT_LO = 10'd323;
    localparam logic [9:0] Y_SAT_LO = 10'd213;
`else
    localparam logic [9:0] X_SAT_HI = 10'd639;
    localparam logic [9:0] X_SAT_LO = 10'd128;
    localparam logic [9:0] Y_SAT_LO = 10'd0;
`endif

    exp_t       sb[$];
    int         ntests = 0;
    int         nfail = 0;
    logic [9:0] cur_x = 10'd320;
    logic [9:0] cur_y = 10'd240;
    logic [9:0] cur_s = 10'd4;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        chk("rst_x", CursorX, 320);
        chk("rst_y", CursorY, 240);
        chk("rst_size", CursorSize, 4);
        chk("rst_pa", pulse_active, 0);
        chk("rst_ready", move_ready, 0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("ready_after_rst", move_ready, 1);
        repeat (4) @(negedge Clk);
        cur_x = 10'd320;
        cur_y = 10'd240;
        cur_s = 10'd4;
    endtask

    task automatic pkt(input int dx, input int dy);
        @(negedge Clk);
        chk("ready_pkt", move_ready, 1);
        move_valid = 1'b1;
        move_dx    = 9'(dx);
        move_dy    = 9'(dy);
        @(negedge Clk);
        move_valid = 1'b0;
    endtask

    task automatic pulse_click();
        @(negedge Clk);
        click = 1'b1;
        @(negedge Clk);
        click = 1'b0;
    endtask

    // hold: present a packet during the tick cycle and keep it until accepted
    task automatic frame(input exp_t e, input bit hold);
        exp_t q;
        bit   seen;
        sb.push_back(e);
        @(negedge Clk);
        frame_clk = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge Clk);
            if (!move_ready)
                seen = 1'b1;
            else
                chk("pre_tick_x", CursorX, cur_x);
        end
        chk("tick_seen", seen, 1);
        if (seen) begin
            chk("tick_hold_x", CursorX, cur_x);
            chk("tick_hold_y", CursorY, cur_y);
            chk("tick_hold_size", CursorSize, cur_s);
            if (hold) begin
                move_valid = 1'b1;
                move_dx    = 9'd7;
                move_dy    = 9'd1;
            end
        end
        @(negedge Clk);
        q = sb.pop_front();
        chk("ready_after_tick", move_ready, 1);
        chk("commit_x", CursorX, q.x);
        chk("commit_y", CursorY, q.y);
        chk("commit_size", CursorSize, q.s);
        chk("commit_pa", pulse_active, q.pa);
        cur_x = q.x;
        cur_y = q.y;
        cur_s = q.s;
        if (hold) begin
            @(negedge Clk);
            move_valid = 1'b0;
        end
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        do_reset();

        pkt(5, 0);
        pkt(-2, 3);
        frame('{10'd323, 10'd243, 10'd4, 1'b0}, 1'b0);

        repeat (3) pkt(255, 0);
        frame('{X_SAT_HI, 10'd243, 10'd4, 1'b0}, 1'b0);

        pkt(-255, -255);
        pkt(-255, -255);
        pkt(-255, 0);
        frame('{X_SAT_LO, Y_SAT_LO, 10'd4, 1'b0}, 1'b0);

        frame('{X_SAT_LO, Y_SAT_LO, 10'd4, 1'b0}, 1'b1);
        frame('{X_SAT_LO + 10'd7, Y_SAT_LO + 10'd1, 10'd4, 1'b0}, 1'b0);

        pulse_click();
        frame('{cur_x, cur_y, 10'd6, 1'b1}, 1'b0);
        frame('{cur_x, cur_y, 10'd8, 1'b1}, 1'b0);
        pulse_click();
        frame('{cur_x, cur_y, 10'd10, 1'b1}, 1'b0);
        frame('{cur_x, cur_y, 10'd8, 1'b1}, 1'b0);
        frame('{cur_x, cur_y, 10'd6, 1'b1}, 1'b0);
        frame('{cur_x, cur_y, 10'd4, 1'b0}, 1'b0);
        frame('{cur_x, cur_y, 10'd4, 1'b0}, 1'b0);

        pulse_click();
        frame('{cur_x, cur_y, 10'd6, 1'b1}, 1'b0);
        pkt(40, 0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("midrst_size", CursorSize, 4);
        chk("midrst_pa", pulse_active, 0);
        chk("midrst_x", CursorX, 320);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        cur_x = 10'd320;
        cur_y = 10'd240;
        cur_s = 10'd4;
        frame('{10'd320, 10'd240, 10'd4, 1'b0}, 1'b0);

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
